dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_lane_align.sv | 27 ++
 rtl/dmem_responder.sv | 76 +++++++
 tb/tb_dmem_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 width codes and FSM state encoding for the data-memory responder
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte enables and lane replication, load extraction and extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);
  logic [31:0] bsh, hsh;
  assign bsh = word >> {off, 3'b000};
  assign hsh = word >> {off[1], 4'b0000};
  assign be = funct3[1:0] == 2'b00 ? 4'b0001 << off
            : funct3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
  assign wword = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}}
               : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}}
               : wdata;
  assign rdata = funct3 == F3_B  ? {{24{bsh[7]}}, bsh[7:0]}
               : funct3 == F3_BU ? {24'd0, bsh[7:0]}
               : funct3 == F3_H  ? {{16{hsh[15]}}, hsh[15:0]}
               : funct3 == F3_HU ? {16'd0, hsh[15:0]}
               : word;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency RV32I data memory with valid/ready request and response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [2:0]               req_funct3,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [1:0] state;
  logic [3:0] cnt;
  logic lat_write;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0] lat_f3;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [3:0] be;
  logic [31:0] wword, ld;
  logic mis, oor, err, fire;
  assign req_ready = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  assign idx = lat_addr[IW+1:2];
  assign fire = state == S_WAIT && cnt == 4'd0;
  assign mis = (lat_f3[1:0] == 2'b01 && lat_addr[0]) || (lat_f3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00);
  assign oor = (lat_addr >> 2) >= ADDRESS_WIDTH'(DEPTH_WORDS);
  assign err = mis || oor || (lat_write ? !(lat_f3 inside {F3_B, F3_H, F3_W})
                                        : !(lat_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}));
  dmem_lane_align u_align (
    .word  (mem[idx]),
    .off   (lat_addr[1:0]),
    .funct3(lat_f3),
    .wdata (lat_wdata),
    .be    (be),
    .wword (wword),
    .rdata (ld)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      lat_write <= req_write;
      lat_addr <= req_addr;
      lat_wdata <= 32'(req_wdata);
      lat_f3 <= req_funct3;
      cnt <= 4'(LATENCY - 1);
      state <= S_WAIT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - (cnt != 4'd0 ? 4'd1 : 4'd0);
      state <= fire ? S_RESP : S_WAIT;
      resp_err <= fire ? err : resp_err;
      resp_rdata <= fire ? ((err || lat_write) ? '0 : DATA_WIDTH'(ld)) : resp_rdata;
    end else if (state == S_RESP && resp_ready)
      state <= S_IDLE;
  always_ff @(posedge clk)
    if (reset && fire && lat_write && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for latency, load/store lanes, errors, backpressure and reset abort
module tb_dmem_responder;
  import dmem_pkg::*;
  localparam int LAT = 2;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0] req_funct3;
  logic [32:0] sb [$];
  int checks = 0;
  int errors = 0;
  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (resp_valid && resp_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        check("rdata", resp_rdata, e[32:1]);
        check("err", 32'(resp_err), 32'(e[0]));
      end
    end
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                      input logic [31:0] er, input logic ee, input int hold);
    int k;
    logic [31:0] rd;
    logic re;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #2; k++; end
    check("ready_wait", 32'(k < 50), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    sb.push_back({er, ee});
    resp_ready = hold == 0;
    @(posedge clk); #2;
    req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    k = 0;
    while (!resp_valid && k < 50) begin @(posedge clk); #2; k++; end
    check("latency", 32'(k), 32'(LAT));
    rd = resp_rdata;
    re = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_err", 32'(resp_err), 32'(re));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    check("back_idle", {30'd0, req_ready, resp_valid}, 32'd2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    xfer(1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 0, 0);
    xfer(1, 32'h13, 32'h00000080, F3_B, 32'h0, 0, 0);
    xfer(0, 32'h13, 32'h0, F3_B, 32'hFFFFFF80, 0, 0);
    xfer(0, 32'h13, 32'h0, F3_BU, 32'h00000080, 0, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 0, 0);
    xfer(0, 32'h11, 32'h0, F3_H, 32'h0, 1, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 0, 0);
    xfer(1, 32'h0, 32'h11111111, F3_W, 32'h0, 0, 0);
    xfer(1, DEPTH * 4, 32'h22222222, F3_W, 32'h0, 1, 0);
    xfer(0, 32'h0, 32'h0, F3_W, 32'h11111111, 0, 0);
    xfer(0, 32'h10, 32'h0, 3'b011, 32'h0, 1, 0);
    xfer(1, 32'h10, 32'h33333333, F3_BU, 32'h0, 1, 0);
    xfer(1, 32'h12, 32'h44444444, F3_W, 32'h0, 1, 0);
    xfer(1, 32'h13, 32'h55555555, F3_H, 32'h0, 1, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'h80ADBEEF, 0, 0);
    xfer(1, 32'h12, 32'hBEEF8765, F3_H, 32'h0, 0, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'h8765BEEF, 0, 0);
    xfer(0, 32'h12, 32'h0, F3_H, 32'hFFFF8765, 0, 0);
    xfer(0, 32'h12, 32'h0, F3_HU, 32'h00008765, 0, 0);
    xfer(0, 32'h11, 32'h0, F3_B, 32'hFFFFFFBE, 0, 0);
    xfer(0, 32'h10, 32'h0, F3_BU, 32'h000000EF, 0, 0);
    xfer(0, 32'h10, 32'h0, F3_W, 32'h8765BEEF, 0, 5);
    xfer(1, 32'h20, 32'hCAFEF00D, F3_W, 32'h0, 0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = F3_W;
    @(posedge clk); #2;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(resp_valid), 32'd0);
    repeat (LAT + 1) @(posedge clk);
    #2;
    check("abort_stay_idle", {30'd0, req_ready, resp_valid}, 32'd2);
    xfer(0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
